// File: rtl/gf180mcu_osu_sc_gp12t3v3__tiebank_if.sv
// Control/observe bundle for the serially programmable tie-off bank.
// The master drives the shift/update/lock controls; the slave returns the straps.
interface gf180mcu_osu_sc_gp12t3v3__tiebank_if #(
    parameter int WIDTH = 8
);
    logic             SE;
    logic             SI;
    logic             UPD;
    logic             LOCK;
    logic [WIDTH-1:0] Y;
    logic             SO;
    logic             ERR;
    logic             LOCKED;

    modport master (
        output SE, SI, UPD, LOCK,
        input  Y, SO, ERR, LOCKED
    );

    modport slave (
        input  SE, SI, UPD, LOCK,
        output Y, SO, ERR, LOCKED
    );
endinterface

// File: rtl/gf180mcu_osu_sc_gp12t3v3__tiebank.sv
// Tie-off constant bank: shadow shift chain committed to Y by a length-checked update.
// Optional even-parity framing is enabled by defining GF180MCU_OSU_SC_TIEBANK_PARITY_EN.
module gf180mcu_osu_sc_gp12t3v3__tiebank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(8'hA5)
) (
    input logic CLK,
    input logic RST,
    gf180mcu_osu_sc_gp12t3v3__tiebank_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 3);
    localparam logic [CW-1:0] CNT_MAX = '1;
`ifdef GF180MCU_OSU_SC_TIEBANK_PARITY_EN
    localparam logic [CW-1:0] FRAME = CW'(WIDTH + 1);
`else
    localparam logic [CW-1:0] FRAME = CW'(WIDTH);
`endif

    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] shadow_q;
    logic [CW-1:0]    cnt_q;
    logic             err_q;
    logic             locked_q;
    logic             frame_ok;
    logic             chain_in;

`ifdef GF180MCU_OSU_SC_TIEBANK_PARITY_EN
    logic p_q;

    // The parity flop heads the chain, so a full frame leaves its parity bit in p.
    always_ff @(posedge CLK) begin
        if (RST) begin
            p_q <= 1'b0;
        end else if (!locked_q && bus.SE) begin
            p_q <= bus.SI;
        end
    end

    assign chain_in = p_q;
    assign frame_ok = (cnt_q == FRAME) && ((^shadow_q ^ p_q) == 1'b0);
`else
    assign chain_in = bus.SI;
    assign frame_ok = (cnt_q == FRAME);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            y_q      <= RESET_VAL;
            shadow_q <= RESET_VAL;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            if (bus.LOCK) begin
                locked_q <= 1'b1;
            end
            // Lock is judged on the registered state, so an update sampled with LOCK still lands.
            if (!locked_q) begin
                if (bus.SE) begin
                    shadow_q <= {shadow_q[WIDTH-2:0], chain_in};
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (bus.UPD) begin
                        err_q <= 1'b1;
                    end
                end else if (bus.UPD) begin
                    cnt_q <= '0;
                    if (frame_ok) begin
                        y_q   <= shadow_q;
                        err_q <= 1'b0;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.Y      = y_q;
    assign bus.SO     = shadow_q[WIDTH-1];
    assign bus.ERR    = err_q;
    assign bus.LOCKED = locked_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__tiebank.sv
// Scoreboard bench for the tie-off bank: directed scenarios followed by random frames,
// each cycle's expected outputs queued by the driver and checked by an independent monitor.
module tb_gf180mcu_osu_sc_gp12t3v3__tiebank;
    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;
`ifdef GF180MCU_OSU_SC_TIEBANK_PARITY_EN
    localparam int FRAME_LEN = W + 1;
`else
    localparam int FRAME_LEN = W;
`endif

    typedef struct packed {
        logic [7:0] y;
        logic       so;
        logic       err;
        logic       locked;
    } obs_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    gf180mcu_osu_sc_gp12t3v3__tiebank_if #(.WIDTH(W)) bus ();

    gf180mcu_osu_sc_gp12t3v3__tiebank #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    obs_t  exp_q[$];
    string tag_q[$];
    int    n_pass  = 0;
    int    n_total = 0;
    string cur_tag = "reset";

    // Reference state: bits shifted since the last update attempt are counted without bound.
    logic [7:0] m_y, m_sh;
    logic       m_err, m_lk, m_p;
    int         m_n;

    task automatic step(input bit rst_i, input bit se_i, input bit si_i,
                        input bit upd_i, input bit lock_i);
        bit    was_locked;
        bit    ok;
        obs_t  e;
        @(negedge CLK);
        RST      = rst_i;
        bus.SE   = se_i;
        bus.SI   = si_i;
        bus.UPD  = upd_i;
        bus.LOCK = lock_i;
        if (rst_i) begin
            m_y = RV; m_sh = RV; m_n = 0; m_err = 1'b0; m_lk = 1'b0; m_p = 1'b0;
        end else begin
            was_locked = m_lk;
            if (lock_i) m_lk = 1'b1;
            if (!was_locked) begin
                if (se_i) begin
`ifdef GF180MCU_OSU_SC_TIEBANK_PARITY_EN
                    m_sh = {m_sh[6:0], m_p};
                    m_p  = si_i;
`else
                    m_sh = {m_sh[6:0], si_i};
`endif
                    m_n++;
                    if (upd_i) m_err = 1'b1;
                end else if (upd_i) begin
                    ok = (m_n == FRAME_LEN);
`ifdef GF180MCU_OSU_SC_TIEBANK_PARITY_EN
                    ok = ok && ((^m_sh ^ m_p) == 1'b0);
`endif
                    if (ok) begin
                        m_y   = m_sh;
                        m_err = 1'b0;
                    end else begin
                        m_err = 1'b1;
                    end
                    m_n = 0;
                end
            end
        end
        e.y = m_y; e.so = m_sh[7]; e.err = m_err; e.locked = m_lk;
        exp_q.push_back(e);
        tag_q.push_back(cur_tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic shift_bits(input logic [8:0] v, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) step(0, 1, v[i], 0, 0);
    endtask

    // Shift a byte and, in the parity build, append its correct even-parity bit.
    task automatic shift_frame(input logic [7:0] v);
`ifdef GF180MCU_OSU_SC_TIEBANK_PARITY_EN
        shift_bits({v, ^v}, 9);
`else
        shift_bits({1'b0, v}, 8);
`endif
    endtask

    task automatic update(input bit lock_i);
        step(0, 0, 0, 1, lock_i);
    endtask

    // Monitor: independent of the driver, pops one expectation per observed edge.
    initial begin
        obs_t  a, e;
        string t;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a.y = bus.Y; a.so = bus.SO; a.err = bus.ERR; a.locked = bus.LOCKED;
                n_total++;
                if (a === e) n_pass++;
                else $display("FAIL %s: got Y=%h SO=%b ERR=%b LOCKED=%b, want Y=%h SO=%b ERR=%b LOCKED=%b",
                              t, a.y, a.so, a.err, a.locked, e.y, e.so, e.err, e.locked);
            end
        end
    end

    initial begin
        int len;
        logic [8:0] v;
        bus.SE = 0; bus.SI = 0; bus.UPD = 0; bus.LOCK = 0;
        m_y = RV; m_sh = RV; m_n = 0; m_err = 0; m_lk = 0; m_p = 0;

        cur_tag = "reset";
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        cur_tag = "idle_hold";
        idle(10);

        cur_tag = "frame_3c";
        shift_frame(8'h3C);
        update(0);

        cur_tag = "short_frame";
        shift_bits(9'h1FF, FRAME_LEN - 1);
        update(0);
        cur_tag = "frame_81";
        shift_frame(8'h81);
        update(0);

        cur_tag = "upd_lock";
        shift_frame(8'h0F);
        update(1);
        cur_tag = "locked_ignore";
        shift_frame(8'hFF);
        update(0);
        idle(2);
        cur_tag = "unlock_reset";
        step(1, 0, 0, 0, 0);
        idle(1);

        cur_tag = "se_upd_collide";
        shift_bits(9'h05A, FRAME_LEN - 1);
        step(0, 1, 1, 1, 0);
        update(0);

        cur_tag = "empty_upd";
        update(0);

`ifdef GF180MCU_OSU_SC_TIEBANK_PARITY_EN
        cur_tag = "parity_good";
        shift_bits({8'h3C, 1'b0}, 9);
        update(0);
        cur_tag = "parity_bad";
        shift_bits({8'h3C, 1'b1}, 9);
        update(0);
        cur_tag = "parity_missing";
        shift_bits({1'b0, 8'h3C}, 8);
        update(0);
`endif

        cur_tag = "random";
        for (int f = 0; f < 60; f++) begin
            len = $urandom_range(FRAME_LEN - 2, FRAME_LEN + 1);
            if ($urandom_range(0, 2) != 0) len = FRAME_LEN;
            v = 9'($urandom);
            for (int i = len - 1; i >= 0; i--)
                step(0, 1, v[i], ($urandom_range(0, 30) == 0), 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            update($urandom_range(0, 14) == 0);
            if (m_lk && $urandom_range(0, 2) == 0) step(1, 0, 0, 0, 0);
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge CLK);
        #2;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
